// File: rtl/router_out_reader.sv
// router_out_reader: drains one packet (header, payload, parity) from a router output port FIFO,
// streams the payload and reports parity status; soft_reset abandons a packet in progress.
module router_out_reader #(
  parameter int DATA_WIDTH  = 8,
  parameter int WAIT_CYCLES = 0
) (
  input  logic                  clock,
  input  logic                  resetn,
  input  logic                  vld_out,
  input  logic [DATA_WIDTH-1:0] data_out,
  input  logic                  soft_reset,
  input  logic                  hold,
  output logic                  read_enb,
  output logic [1:0]            rx_addr,
  output logic [5:0]            rx_len,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  rx_data_valid,
  output logic                  pkt_done,
  output logic                  parity_err,
  output logic                  abort,
  output logic                  busy_rd
);
  typedef enum logic [1:0] {IDLE, WAIT, READ, DONE} state_t;
  state_t                state;
  logic [5:0]            wcnt;
  logic [6:0]            issued, rcv;
  logic                  rd_d, hdr, pay, par;
  logic [DATA_WIDTH-1:0] acc;
  // The first two reads go out before the header is decoded; every packet has at least two bytes.
  always_comb begin
    read_enb      = state == READ && vld_out && !hold &&
                    (issued < 7'd2 || issued < {1'b0, rx_len} + 7'd2);
    hdr           = state == READ && rd_d && rcv == 7'd0;
    pay           = state == READ && rd_d && rcv != 7'd0 && rcv <= {1'b0, rx_len};
    par           = state == READ && rd_d && rcv == {1'b0, rx_len} + 7'd1;
    rx_data_valid = pay;
    rx_data       = pay ? data_out : '0;
    busy_rd       = state != IDLE;
  end
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state      <= IDLE;
      wcnt       <= '0;
      issued     <= '0;
      rcv        <= '0;
      rd_d       <= 1'b0;
      acc        <= '0;
      rx_addr    <= '0;
      rx_len     <= '0;
      pkt_done   <= 1'b0;
      parity_err <= 1'b0;
      abort      <= 1'b0;
    end else begin
      pkt_done   <= 1'b0;
      parity_err <= 1'b0;
      abort      <= 1'b0;
      if (soft_reset && state != IDLE) begin
        state  <= IDLE;
        wcnt   <= '0;
        issued <= '0;
        rcv    <= '0;
        rd_d   <= 1'b0;
        acc    <= '0;
        abort  <= 1'b1;
      end else begin
        case (state)
          IDLE: if (vld_out) begin
            state <= WAIT_CYCLES == 0 ? READ : WAIT;
            wcnt  <= '0;
          end
          WAIT: if (wcnt == 6'(WAIT_CYCLES - 1)) state <= READ;
                else wcnt <= wcnt + 6'd1;
          READ: begin
            rd_d   <= read_enb;
            issued <= issued + 7'(read_enb);
            if (rd_d) rcv <= rcv + 7'd1;
            if (hdr) begin
              rx_len  <= data_out[7:2];
              rx_addr <= data_out[1:0];
              acc     <= data_out;
            end
            if (pay) acc <= acc ^ data_out;
            if (par) begin
              state      <= DONE;
              pkt_done   <= 1'b1;
              parity_err <= data_out != acc;
            end
          end
          DONE: begin
            state  <= IDLE;
            issued <= '0;
            rcv    <= '0;
            rd_d   <= 1'b0;
            acc    <= '0;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_router_out_reader.sv
// tb_router_out_reader: directed packets through a FIFO model, checked with immediate assertions.
module tb_router_out_reader;
  logic       clock = 1'b0, resetn = 1'b0, vld = 1'b0, srst = 1'b0, hold = 1'b0, vld4 = 1'b0;
  logic [7:0] dout = 8'h00, dout4 = 8'h14;
  logic       re, rvalid, done, perr, abrt, busy;
  logic [1:0] addr;
  logic [5:0] len;
  logic [7:0] rdata;
  logic       re4, rvalid4, done4, perr4, abrt4, busy4;
  logic [1:0] addr4;
  logic [5:0] len4;
  logic [7:0] rdata4;
  int         tests = 0, fails = 0, nrd, ndone, nabort, first, held;
  logic       perr_seen, s_re, s_busy, s_abort;
  logic [7:0] q[$], got[$], exp[$];

  router_out_reader #(.DATA_WIDTH(8), .WAIT_CYCLES(0)) u0 (
    .clock(clock), .resetn(resetn), .vld_out(vld), .data_out(dout), .soft_reset(srst),
    .hold(hold), .read_enb(re), .rx_addr(addr), .rx_len(len), .rx_data(rdata),
    .rx_data_valid(rvalid), .pkt_done(done), .parity_err(perr), .abort(abrt), .busy_rd(busy));

  router_out_reader #(.DATA_WIDTH(8), .WAIT_CYCLES(4)) u4 (
    .clock(clock), .resetn(resetn), .vld_out(vld4), .data_out(dout4), .soft_reset(srst),
    .hold(hold), .read_enb(re4), .rx_addr(addr4), .rx_len(len4), .rx_data(rdata4),
    .rx_data_valid(rvalid4), .pkt_done(done4), .parity_err(perr4), .abort(abrt4), .busy_rd(busy4));

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Samples outputs at the falling edge, then plays the FIFO: a read strobe yields data next cycle.
  task automatic cyc();
    logic r;
    @(negedge clock);
    s_re = re; s_busy = busy; s_abort = abrt;
    nrd += int'(re);
    if (rvalid) got.push_back(rdata);
    if (done) begin ndone++; perr_seen = perr; end
    if (abrt) nabort++;
    r = re;
    @(posedge clock);
    #1;
    if (r) begin
      if (q.size() != 0) dout = q.pop_front();
      else dout = 8'hEE;
    end
    vld = q.size() != 0;
  endtask

  task automatic clear_mon();
    nrd = 0; ndone = 0; nabort = 0; perr_seen = 1'b0;
    got.delete();
  endtask

  task automatic pkt_check(input string t, input int erd, input logic [1:0] ea,
                           input logic [5:0] el, input logic ep);
    chk({t, "_reads"}, nrd, erd);
    chk({t, "_addr"}, addr, ea);
    chk({t, "_len"}, len, el);
    chk({t, "_done"}, ndone, 1);
    chk({t, "_perr"}, perr_seen, ep);
    chk({t, "_abort"}, nabort, 0);
    chk({t, "_nbytes"}, got.size(), exp.size());
    for (int i = 0; i < exp.size(); i++) chk({t, "_byte"}, got[i], exp[i]);
    chk({t, "_busy_end"}, s_busy, 0);
  endtask

  initial begin
    repeat (2) @(posedge clock);
    #1;
    chk("reset_u0", {re, addr, len, rdata, rvalid, done, perr, abrt, busy}, 0);
    chk("reset_u4", {re4, addr4, len4, rdata4, rvalid4, done4, perr4, abrt4, busy4}, 0);
    resetn = 1'b1;
    cyc();
    chk("idle_busy", s_busy, 0);

    // 1: len 3, addr 1, good parity
    clear_mon();
    q = '{8'h0D, 8'h11, 8'h22, 8'h33, 8'h0D}; vld = 1'b1;
    exp = '{8'h11, 8'h22, 8'h33};
    repeat (15) cyc();
    pkt_check("t1", 5, 2'd1, 6'd3, 1'b0);

    // 2: same packet, bad parity
    clear_mon();
    q = '{8'h0D, 8'h11, 8'h22, 8'h33, 8'h0C}; vld = 1'b1;
    repeat (15) cyc();
    pkt_check("t2", 5, 2'd1, 6'd3, 1'b1);

    // 3: zero-length packet
    clear_mon();
    q = '{8'h02, 8'h02}; vld = 1'b1;
    exp.delete();
    repeat (10) cyc();
    pkt_check("t3", 2, 2'd2, 6'd0, 1'b0);

    // 4: len 5 with a 3-cycle hold after the second payload byte
    clear_mon();
    q = '{8'h17, 8'hA1, 8'hB2, 8'hC3, 8'hD4, 8'hE5, 8'hF6}; vld = 1'b1;
    exp = '{8'hA1, 8'hB2, 8'hC3, 8'hD4, 8'hE5};
    for (int i = 0; i < 20 && got.size() < 2; i++) cyc();
    chk("t4_reach2", got.size(), 2);
    hold = 1'b1;
    held = 0;
    repeat (3) begin cyc(); held += int'(s_re); end
    chk("t4_hold_reads", held, 0);
    hold = 1'b0;
    repeat (15) cyc();
    pkt_check("t4", 7, 2'd3, 6'd5, 1'b0);

    // 5: len 10 aborted by soft_reset, then a clean packet
    clear_mon();
    q = '{8'h28, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h09, 8'h0A, 8'h28};
    vld = 1'b1;
    for (int i = 0; i < 20 && got.size() < 4; i++) cyc();
    chk("t5_reach4", got.size(), 4);
    srst = 1'b1;
    cyc();
    srst = 1'b0;
    q.delete(); vld = 1'b0;
    cyc();
    chk("t5_abort", s_abort, 1);
    chk("t5_re_low", s_re, 0);
    chk("t5_busy_low", s_busy, 0);
    held = got.size();
    repeat (5) cyc();
    chk("t5_abort_once", nabort, 1);
    chk("t5_no_done", ndone, 0);
    chk("t5_no_more_bytes", got.size(), held);
    clear_mon();
    q = '{8'h0D, 8'h11, 8'h22, 8'h33, 8'h0D}; vld = 1'b1;
    exp = '{8'h11, 8'h22, 8'h33};
    repeat (15) cyc();
    pkt_check("t5_after", 5, 2'd1, 6'd3, 1'b0);

    // 6: WAIT_CYCLES=4 start latency, then async reset mid-payload
    first = -1;
    vld4 = 1'b1;
    for (int c = 0; c < 9; c++) begin
      @(negedge clock);
      if (re4 && first < 0) first = c;
      @(posedge clock);
      #1;
    end
    chk("t6_first_read", first, 5);
    chk("t6_mid_valid", rvalid4, 1);
    chk("t6_mid_len", len4, 5);
    #2 resetn = 1'b0;
    #1;
    chk("t6_async_reset", {re4, addr4, len4, rdata4, rvalid4, done4, perr4, abrt4, busy4}, 0);
    vld4 = 1'b0;
    repeat (2) @(posedge clock);
    resetn = 1'b1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
